// File: rtl/pic_interrupt_resolver.sv
// rtl/pic_interrupt_resolver.sv - 8259A IR synchroniser, IRR/ISR and rotating priority resolver.
// Produces the registered one-hot winning request and the one-hot highest in-service level.
module pic_interrupt_resolver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ir_in,
  input  logic       init_clear,
  input  logic       LTIM,
  input  logic       special_fully_nest,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] EOI,
  input  logic       freeze,
  input  logic       latch_in_service,
  input  logic [7:0] clear_interrupt_request,
  input  logic [2:0] priority_rotate,
  output logic [7:0] interrupt,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register
);

  function automatic logic [7:0] rot_right(input logic [7:0] v, input logic [2:0] r);
    logic [7:0] o;
    logic [2:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx  = 3'(i) + r;
      o[i] = v[idx];
    end
    return o;
  endfunction

  function automatic logic [7:0] rot_left(input logic [7:0] v, input logic [2:0] r);
    logic [7:0] o;
    logic [2:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx    = 3'(i) + r;
      o[idx] = v[i];
    end
    return o;
  endfunction

  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    logic [7:0] o;
    logic       found;
    o     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        o[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return o;
  endfunction

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [7:0] ir_prev_q, ir_prev_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] interrupt_q, interrupt_d;
  logic [7:0] ir_s;
  logic [2:0] rot_amt;
  logic [7:0] req_rot_pick;
  logic [7:0] isr_rot_pick;
  logic       grant;

  assign ir_s = sync_q[SYNC_STAGES-1];

  // Picks are compared in rotated space, where a lower one-hot value means higher priority.
  always_comb begin
    rot_amt      = priority_rotate + 3'd1;
    req_rot_pick = lowest_bit(rot_right(irr_q & ~interrupt_mask, rot_amt));
    isr_rot_pick = lowest_bit(rot_right(isr_q, rot_amt));
    grant        = (req_rot_pick != 8'h00) &&
                   ((isr_rot_pick == 8'h00) || (req_rot_pick < isr_rot_pick) ||
                    (special_fully_nest && (req_rot_pick == isr_rot_pick)));
  end

  always_comb begin
    sync_d[0] = ir_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    ir_prev_d = init_clear ? 8'hFF : ir_s;

    irr_d = irr_q;
    for (int i = 0; i < 8; i++) begin
      if (clear_interrupt_request[i])   irr_d[i] = 1'b0;
      else if (freeze)                  irr_d[i] = irr_q[i];
      else if (!LTIM) begin
        if (ir_s[i] && !ir_prev_q[i])   irr_d[i] = 1'b1;
        else if (!ir_s[i])              irr_d[i] = 1'b0;
      end else                          irr_d[i] = ir_s[i];
    end

    isr_d       = (isr_q & ~EOI) | (latch_in_service ? interrupt_q : 8'h00);
    interrupt_d = grant ? rot_left(req_rot_pick, rot_amt) : 8'h00;

    if (init_clear) begin
      irr_d       = 8'h00;
      isr_d       = 8'h00;
      interrupt_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'hFF;
      ir_prev_q   <= 8'hFF;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      interrupt_q <= 8'h00;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      ir_prev_q   <= ir_prev_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt                  = interrupt_q;
  assign highest_level_in_service   = rot_left(isr_rot_pick, rot_amt);
  assign interrupt_request_register = irr_q;
  assign in_service_register        = isr_q;

endmodule

// File: doc/pic_interrupt_resolver.md
Name: pic_interrupt_resolver

Overview:
Interrupt request/in-service stage of the 8259A PIC, directly upstream of the control logic. It synchronises the eight IR pins and builds the interrupt request register (IRR) in edge or level mode. It maintains the in-service register (ISR) and resolves priority with rotation. It supplies the control logic with the one-hot winning `interrupt` and the one-hot `highest_level_in_service`, and acts on that block's mask, EOI, freeze, latch and rotate controls.

Parameters:
SYNC_STAGES, 2, number of flops in the IR pin synchroniser (minimum 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
ir_in  input  8  raw IR0..IR7 pins, asynchronous
init_clear  input  1  one-cycle pulse on an ICW1 write; synchronous re-initialise
LTIM  input  1  0 = edge-triggered, 1 = level-triggered
special_fully_nest  input  1  1 = a request equal in priority to the highest ISR bit may also win
interrupt_mask  input  8  OCW1 mask; 1 = masked
EOI  input  8  per-bit ISR clear
freeze  input  1  1 = IRR pin-driven updates suspended
latch_in_service  input  1  pulse: set the ISR bit of the current `interrupt`
clear_interrupt_request  input  8  per-bit IRR clear on acknowledge
priority_rotate  input  3  lowest-priority level; highest = priority_rotate+1 mod 8
interrupt  output  8  one-hot winning request, registered; 0 = none
highest_level_in_service  output  8  one-hot highest-priority ISR bit, combinational from ISR; 0 = none
interrupt_request_register  output  8  IRR contents
in_service_register  output  8  ISR contents

Behaviour:
- Reset (async, reset_n=0):
  - Synchroniser flops and edge-history register ir_prev go to 8'hFF. A pin held high through reset release therefore produces no edge.
  - IRR, ISR and `interrupt` go to 0. highest_level_in_service therefore reads 0.
- Synchroniser: ir_s = ir_in delayed SYNC_STAGES clocks. ir_prev <= ir_s every cycle.
- IRR next-state per bit i, evaluated in priority order:
  1. init_clear=1: IRR <= 0, ISR <= 0, ir_prev <= 8'hFF, `interrupt` <= 0. Overrides everything else that cycle.
  2. clear_interrupt_request[i]=1: bit i <= 0. Wins over a same-cycle set.
  3. freeze=1: bit holds.
  4. LTIM=0 (edge mode): set on ir_s[i] & ~ir_prev[i]; clear when ir_s[i]=0 (request withdrawn); otherwise hold.
  5. LTIM=1 (level mode): bit <= ir_s[i].
- Masked request: req = IRR & ~interrupt_mask. The mask never alters IRR.
- Priority order: rotation amount r = priority_rotate+1 (3-bit wrap).
  - Rotate the vector right by r, take the lowest set bit, rotate back left by r.
  - Reset value priority_rotate=7 gives IR0 highest, IR7 lowest.
- highest_level_in_service: priority pick applied to ISR.
- `interrupt` register:
  - Loads the priority pick of req if that bit is strictly higher in priority than highest_level_in_service, or equal when special_fully_nest=1.
  - Loads 0 otherwise, including when req=0.
  - Always comparison is made in rotated space; an empty ISR always permits the request.
- ISR per bit:
  - ISR <= (ISR & ~EOI) | (latch_in_service ? interrupt : 0).
  - When set and clear hit the same bit in one cycle, set wins.
- Latency:
  - ir_in rise to IRR bit set: SYNC_STAGES+1 clocks.
  - IRR/ISR/mask/rotate change to `interrupt` update: 1 clock.
- Masking mid-pending: `interrupt` drops to 0 (or the next candidate) one clock after the mask write.
- Rotate change: takes effect for both priority picks in the same cycle as the input change, reflected in `interrupt` one clock later.
- Arithmetic: all rotations are modulo 8. No other arithmetic.

Test Plan:
- Reset with ir_in=8'h01 held, LTIM=0, release reset_n -> IRR stays 0 indefinitely; drop IR0 and re-raise -> IRR=8'h01 after 3 clocks, `interrupt`=8'h01 one clock later.
- Edge mode, ir_in 8'h00->8'h28, mask 0, rotate 7 -> `interrupt`=8'h08; set interrupt_mask=8'h08 -> `interrupt`=8'h20 next clock.
- latch_in_service with `interrupt`=8'h08 -> ISR=8'h08, highest_level_in_service=8'h08. Then raise IR1 -> `interrupt`=8'h02; raise IR5 only -> `interrupt`=0; set special_fully_nest=1 with IR3 pending -> `interrupt`=8'h08.
- priority_rotate=3, IRR=8'h11 -> `interrupt`=8'h10 (IR4 highest); priority_rotate=7 -> `interrupt`=8'h01.
- Same cycle: latch_in_service with `interrupt`=8'h04, EOI=8'h04, clear_interrupt_request=8'h04 while ir edge on IR2 -> ISR bit2=1, IRR bit2=0.
- Level mode (LTIM=1), freeze=1, toggle ir_in -> IRR holds; freeze=0 -> IRR tracks ir_s. Mid-run init_clear pulse -> IRR, ISR, `interrupt` all 0 next clock, no spurious edge from pins already high.
